mux4x1_rr_arbiter: RTL and testbench
====================================

Name: mux4x1_rr_arbiter

Overview:
Round-robin arbiter that shares one mux4x1 instance between four requesters. It drives the mux select `s` and returns a one-hot grant to the winning requester. Grants are held for as long as the owner keeps its request asserted. It sits directly in front of mux4x1: `sel` connects to mux `s`, and requester i drives mux `i[i]`.

Parameters:
MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while others wait (used only with ARB_TIMEOUT_EN; legal range 2..255).
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-high; one clock, no other reset.
req  input  4  request vector; req[k] high = requester k wants the mux; held until done.
gnt  output 4  one-hot grant, registered; all-zero when idle.
sel  output 2  mux select, registered, equals index of current/last owner.
busy output 1  high while any grant is active (gnt != 0).

Behaviour:
- All outputs are registered; no combinational path from req to any output.
- Reset (async assert, sync release):
  - gnt=4'b0000, sel=2'b00, busy=0, state=IDLE.
  - Internal last-owner pointer `last`=3, so requester 0 has top priority after reset.
  - Hold counter = 0.
- Reset asserted mid-grant: outputs go to reset values immediately, without waiting for a clock edge.
- Priority order: search starts at (last+1) mod 4 and wraps around (3 -> 0); first requester with req high wins.
- States: IDLE, GRANT.
- IDLE:
  - req==0: stay in IDLE; gnt=0; sel holds its previous value so the mux output stays stable.
  - req!=0 sampled at edge n: at edge n+1 enter GRANT, gnt=onehot(w), sel=w, busy=1. Latency from request to grant is 1 cycle.
- GRANT, owner g:
  - req[g]=1: keep grant; other requesters wait.
  - req[g]=0 and another request pending: next edge grants the next winner, searched from g+1, with no idle bubble; last=g.
  - req[g]=0 and no other request: next edge returns to IDLE; gnt=0, busy=0, sel stays g, last=g.
- Requests arriving in the same cycle as a release are treated as pending and take part in that edge's arbitration.
- A requester that releases and re-asserts in the next cycle is rotated to lowest priority behind any waiting requesters.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit whenever busy=1.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - Hold counter increments each cycle in GRANT and clears to 0 on every grant change or on entry to IDLE.
  - When counter == MAX_HOLD-1 and any other req bit is high, the next edge forcibly rotates the grant to the next winner (last=g), even though req[g] is still high.
  - If no other requester is waiting, the owner keeps the grant and the counter clears to 0.
- Undefined: the counter is not synthesized; the grant is held indefinitely while req[g]=1.

Test Plan:
1. Reset check: assert rst mid-cycle with req=4'b1111 -> gnt=0000, sel=00, busy=0 immediately; after release, first grant is gnt=0001, sel=00 one cycle later.
2. Round-robin rotation: req=4'b1111 constant, each owner drops its req for 1 cycle after 3 cycles of grant -> grant order 0,1,2,3,0 with no idle cycles; sel follows 00,01,10,11,00. Mux with i=4'b1010 shows o=0,1,0,1.
3. Wrap-around: after owner 3 releases, req=4'b0101 -> gnt=0001 (not 0100); then owner 0 releases -> gnt=0100.
4. Idle and sel hold: single req[2] pulse for 4 cycles, then req=0 -> gnt=0100 for 4 cycles, then gnt=0000, busy=0, sel stays 10.
5. Simultaneous release and request: owner 1 drops req[1] in the same cycle req[3] rises -> next edge gnt=1000, no IDLE cycle.
6. ARB_TIMEOUT_EN, MAX_HOLD=8: req[0] held high, req[2] raised at grant cycle 1 -> gnt=0001 for exactly 8 cycles, then 0100. Without the macro, gnt=0001 persists for 50+ cycles.

Source files
------------

// File: rtl/mux4x1_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the mux4x1 round-robin arbiter.
// master: requester side (drives req). slave: arbiter side (drives gnt/sel/busy).
interface mux4x1_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    modport master (output req, input gnt, input sel, input busy);
    modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter sharing one mux4x1 between four requesters.
// Grants are held while the owner keeps req high; sel drives mux s directly.
// Optional macro ARB_TIMEOUT_EN: forces rotation after MAX_HOLD cycles when others wait.
module mux4x1_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mux4x1_rr_arbiter_if.slave      bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic [1:0] last;

    // Reject configurations where the hold counter cannot reach MAX_HOLD-1.
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_cfg_err
        $error("mux4x1_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    // First requester after base, wrapping 3 -> 0; {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk farthest-first so the nearest hit is the one left in res.
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [1:0] base;
    logic [2:0] pick;
    logic       owner_hold;

    // Next-winner search: from last owner when idle, from current owner when granting.
    // The owner is masked out so a forced rotation never re-picks it.
    always_comb begin
        base       = (state == IDLE) ? last : sel_q;
        pick       = rr_pick(bus.req & ~gnt_q, base);
        owner_hold = |(bus.req & gnt_q);
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             hold_expired;

    // Hold window exhausted for the current owner.
    always_comb hold_expired = (cnt == CNT_W'(MAX_HOLD - 1));
`endif

    // Arbiter FSM with registered grant, select and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= 4'b0000;
            sel_q  <= 2'b00;
            busy_q <= 1'b0;
            last   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick[2]) begin
                        state  <= GRANT;
                        gnt_q  <= 4'b0001 << pick[1:0];
                        sel_q  <= pick[1:0];
                        busy_q <= 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                GRANT: begin
                    if (!owner_hold) begin
                        // Owner released: hand over without a bubble, or go idle with sel parked.
                        last <= sel_q;
                        if (pick[2]) begin
                            gnt_q <= 4'b0001 << pick[1:0];
                            sel_q <= pick[1:0];
                        end else begin
                            state  <= IDLE;
                            gnt_q  <= 4'b0000;
                            busy_q <= 1'b0;
                        end
`ifdef ARB_TIMEOUT_EN
                        cnt <= '0;
                    end else if (hold_expired) begin
                        // Window used up: rotate if someone waits, else restart the window.
                        cnt <= '0;
                        if (pick[2]) begin
                            last  <= sel_q;
                            gnt_q <= 4'b0001 << pick[1:0];
                            sel_q <= pick[1:0];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed self-checking bench for mux4x1_rr_arbiter (honours ARB_TIMEOUT_EN if defined).
module tb_mux4x1_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] mux_i = 4'b1010;
    logic       mux_o;

    mux4x1_rr_arbiter_if bus();

    mux4x1_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream mux4x1.
    always_comb mux_o = mux_i[bus.sel];

    // Advance one edge; sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = 4'b0000;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0000_00_0) begin
            failures++;
            $display("FAIL reset_state got gnt=%b sel=%b busy=%b want 0000 00 0", bus.gnt, bus.sel, bus.busy);
        end
        rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0001_00_1) begin
            failures++;
            $display("FAIL first_grant got gnt=%b sel=%b busy=%b want 0001 00 1", bus.gnt, bus.sel, bus.busy);
        end
        tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0000_00_0) begin
            failures++;
            $display("FAIL async_reset got gnt=%b sel=%b busy=%b want 0000 00 0", bus.gnt, bus.sel, bus.busy);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0001_00_1) begin
            failures++;
            $display("FAIL post_reset_grant got gnt=%b sel=%b busy=%b want 0001 00 1", bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        logic       exp_o;
        do_reset();
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_s = 2'(k % 4);
            exp_g = 4'b0001 << exp_s;
            exp_o = (exp_s == 2'd1 || exp_s == 2'd3);
            checks++;
            if ({bus.gnt, bus.sel, bus.busy, mux_o} !== {exp_g, exp_s, 1'b1, exp_o}) begin
                failures++;
                $display("FAIL rotation_%0d got gnt=%b sel=%b busy=%b o=%b want %b %b 1 %b",
                         k, bus.gnt, bus.sel, bus.busy, mux_o, exp_g, exp_s, exp_o);
            end
            tick(); tick();
            checks++;
            if (bus.gnt !== exp_g) begin
                failures++;
                $display("FAIL rotation_hold_%0d got gnt=%b want %b", k, bus.gnt, exp_g);
            end
            bus.req[exp_s] = 1'b0;
            tick();
            bus.req[exp_s] = 1'b1;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 4'b1000;
        tick();
        checks++;
        if ({bus.gnt, bus.sel} !== 6'b1000_11) begin
            failures++;
            $display("FAIL wrap_owner3 got gnt=%b sel=%b want 1000 11", bus.gnt, bus.sel);
        end
        bus.req = 4'b0101;
        tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0001_00_1) begin
            failures++;
            $display("FAIL wrap_to_0 got gnt=%b sel=%b busy=%b want 0001 00 1", bus.gnt, bus.sel, bus.busy);
        end
        bus.req = 4'b0100;
        tick();
        checks++;
        if ({bus.gnt, bus.sel} !== 6'b0100_10) begin
            failures++;
            $display("FAIL wrap_then_2 got gnt=%b sel=%b want 0100 10", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_idle_hold();
        int held;
        do_reset();
        bus.req = 4'b0100;
        held = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.gnt === 4'b0100 && bus.sel === 2'b10) held++;
        end
        checks++;
        if (held != 4) begin
            failures++;
            $display("FAIL idle_grant_cycles got %0d want 4", held);
        end
        bus.req = 4'b0000;
        tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0000_10_0) begin
            failures++;
            $display("FAIL idle_release got gnt=%b sel=%b busy=%b want 0000 10 0", bus.gnt, bus.sel, bus.busy);
        end
        tick(); tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b0000_10_0) begin
            failures++;
            $display("FAIL idle_sel_hold got gnt=%b sel=%b busy=%b want 0000 10 0", bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 4'b0010;
        tick(); tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_owner1 got gnt=%b want 0010", bus.gnt);
        end
        bus.req = 4'b1000;
        tick();
        checks++;
        if ({bus.gnt, bus.sel, bus.busy} !== 7'b1000_11_1) begin
            failures++;
            $display("FAIL b2b_handover got gnt=%b sel=%b busy=%b want 1000 11 1", bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_reassert();
        do_reset();
        bus.req = 4'b0111;
        tick();
        bus.req = 4'b0110;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010) begin
            failures++;
            $display("FAIL reassert_owner1 got gnt=%b want 0010", bus.gnt);
        end
        bus.req = 4'b0111;
        tick();
        bus.req = 4'b0101;
        tick();
        checks++;
        if (bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL reassert_order got gnt=%b want 0100", bus.gnt);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0101;
        n = 0;
        while (bus.gnt === 4'b0001 && n < 60) begin
            n++;
            tick();
        end
        checks++;
        if (n != 8 || bus.gnt !== 4'b0100) begin
            failures++;
            $display("FAIL timeout_rotate got %0d cycles then gnt=%b want 8 then 0100", n, bus.gnt);
        end
    endtask
`else
    task automatic test_hold_forever();
        int n;
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0101;
        n = 0;
        for (int i = 0; i < 55; i++) begin
            if (bus.gnt === 4'b0001) n++;
            tick();
        end
        checks++;
        if (n != 55) begin
            failures++;
            $display("FAIL hold_forever got %0d cycles of 0001 want 55", n);
        end
    endtask
`endif

    initial begin
        bus.req = 4'b0000;
        test_reset();
        test_rotation();
        test_wrap();
        test_idle_hold();
        test_back_to_back();
        test_reassert();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
